// File: rtl/maxnet_sequencer_if.sv
// Handshake and status bundle between the MaxNet sequencer (master) and its FP datapath (slave).
// Optional macro MAXNET_WDOG_EN adds the dp_timeout status line.
interface maxnet_sequencer_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned ITER_W = 6
);
  localparam int unsigned WIN_W = (N > 1) ? $clog2(N) : 1;

  logic              start;
  logic              dp_valid;
  logic [N-1:0]      nonzero;
  logic              ld_init;
  logic              dp_start;
  logic              ld_act;
  logic              busy;
  logic              done;
  logic [WIN_W-1:0]  winner;
  logic              no_winner;
  logic              iter_limit;
  logic [ITER_W-1:0] iter_cnt;
`ifdef MAXNET_WDOG_EN
  logic              dp_timeout;
`endif

  modport master (
    input  start, dp_valid, nonzero,
`ifdef MAXNET_WDOG_EN
    output dp_timeout,
`endif
    output ld_init, dp_start, ld_act, busy, done, winner, no_winner, iter_limit, iter_cnt
  );

  modport slave (
    output start, dp_valid, nonzero,
`ifdef MAXNET_WDOG_EN
    input  dp_timeout,
`endif
    input  ld_init, dp_start, ld_act, busy, done, winner, no_winner, iter_limit, iter_cnt
  );
endinterface

// File: rtl/maxnet_sequencer.sv
// Control FSM for the 4-input floating-point MaxNet: load, iterate lateral inhibition, report winner.
// Optional macro MAXNET_WDOG_EN adds a WAIT-state watchdog and the dp_timeout flag.
module maxnet_sequencer #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned ITER_W   = 6
`ifdef MAXNET_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_sequencer_if.master  bus
);
  localparam int unsigned       WIN_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned       POP_W    = $clog2(N + 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
`ifdef MAXNET_WDOG_EN
  localparam int unsigned       WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_UPDATE, S_CHECK, S_DONE
  } state_e;

  state_e            state_q;
  logic              ld_init_q, dp_start_q, ld_act_q, busy_q, done_q;
  logic              no_winner_q, iter_limit_q;
  logic [WIN_W-1:0]  winner_q;
  logic [ITER_W-1:0] iter_cnt_q;
  logic [POP_W-1:0]  pop_d;
  logic [WIN_W-1:0]  low_idx_d;
`ifdef MAXNET_WDOG_EN
  logic              dp_timeout_q;
  logic [WDOG_W-1:0] wdog_q;
`endif

  // Survivor count and lowest surviving index (scan high to low so the lowest wins).
  always_comb begin
    pop_d     = '0;
    low_idx_d = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bus.nonzero[i]) begin
        pop_d     = pop_d + POP_W'(1);
        low_idx_d = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ld_init_q    <= 1'b0;
      dp_start_q   <= 1'b0;
      ld_act_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      no_winner_q  <= 1'b0;
      iter_limit_q <= 1'b0;
      winner_q     <= '0;
      iter_cnt_q   <= '0;
`ifdef MAXNET_WDOG_EN
      dp_timeout_q <= 1'b0;
      wdog_q       <= '0;
`endif
    end else begin
      ld_init_q  <= 1'b0;
      dp_start_q <= 1'b0;
      ld_act_q   <= 1'b0;
      case (state_q)
        // Flags and counter clear on entry so they already read 0 while ld_init is high.
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q      <= S_LOAD;
            ld_init_q    <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            no_winner_q  <= 1'b0;
            iter_limit_q <= 1'b0;
            winner_q     <= '0;
            iter_cnt_q   <= '0;
`ifdef MAXNET_WDOG_EN
            dp_timeout_q <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state_q    <= S_ISSUE;
          dp_start_q <= 1'b1;
`ifdef MAXNET_WDOG_EN
          wdog_q     <= '0;
`endif
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.dp_valid) begin
            state_q  <= S_UPDATE;
            ld_act_q <= 1'b1;
          end
`ifdef MAXNET_WDOG_EN
          else if (wdog_q == WDOG_LAST) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            winner_q     <= '0;
            dp_timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
`endif
        end
        S_UPDATE: begin
          state_q <= S_CHECK;
          if (iter_cnt_q != ITER_MAX) iter_cnt_q <= iter_cnt_q + ITER_W'(1);
        end
        // nonzero now reflects the activations committed during UPDATE.
        S_CHECK: begin
          if (pop_d == POP_W'(1)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            winner_q <= low_idx_d;
          end else if (pop_d == '0) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            no_winner_q <= 1'b1;
            winner_q    <= '0;
          end else if (iter_cnt_q == ITER_MAX) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            iter_limit_q <= 1'b1;
            winner_q     <= low_idx_d;
          end else begin
            state_q    <= S_ISSUE;
            dp_start_q <= 1'b1;
`ifdef MAXNET_WDOG_EN
            wdog_q     <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_init    = ld_init_q;
  assign bus.dp_start   = dp_start_q;
  assign bus.ld_act     = ld_act_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.winner     = winner_q;
  assign bus.no_winner  = no_winner_q;
  assign bus.iter_limit = iter_limit_q;
  assign bus.iter_cnt   = iter_cnt_q;
`ifdef MAXNET_WDOG_EN
  assign bus.dp_timeout = dp_timeout_q;
`endif

endmodule

// File: doc/maxnet_sequencer.md
Name: maxnet_sequencer

Overview:
- Control FSM for the 4-input floating-point MaxNet (neutralNetwork) datapath.
- Loads the four IEEE-754 activations, then issues one lateral-inhibition iteration at a time.
- Waits for the multi-cycle FP datapath to finish each iteration, then commits the new activations.
- Stops when at most one activation is still nonzero, or when the iteration limit is reached; reports done, the winner index and status flags.

Parameters:
- N, 4, number of neurons/activations (winner width = clog2(N)).
- MAX_ITER, 32, iteration limit before forced termination.
- ITER_W, 6, width of the iteration counter; must hold MAX_ITER.
- WDOG_CYCLES, 64, WAIT-state watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new search; sampled in IDLE or DONE only.
- dp_valid  in  1  datapath has finished the current iteration; results are ready.
- nonzero  in  N  per-neuron flag: committed activation > 0 (sign=0 and exponent/mantissa != 0), driven from the datapath registers.
- ld_init  out  1  one-cycle pulse: load x1..xN into the activation registers.
- dp_start  out  1  one-cycle pulse: start one iteration.
- ld_act  out  1  one-cycle pulse: commit the iteration results to the activation registers.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE (level).
- winner  out  clog2(N)  index of the surviving neuron.
- no_winner  out  1  all activations were zero at termination.
- iter_limit  out  1  terminated because MAX_ITER was reached.
- iter_cnt  out  ITER_W  number of completed iterations.

Behaviour:
- Reset (rst=1 at the clock edge, in any state, including mid-iteration):
  - state goes to IDLE;
  - every output is 0, including iter_cnt, winner and the flags.
- States: IDLE, LOAD, ISSUE, WAIT, UPDATE, CHECK, DONE.
- IDLE: start=1 -> LOAD.
- LOAD: ld_init=1; iter_cnt<=0; no_winner, iter_limit and winner cleared -> ISSUE.
- ISSUE: dp_start=1 -> WAIT.
- WAIT: stays until dp_valid=1 -> UPDATE. dp_valid in any other state is ignored.
- UPDATE: ld_act=1; iter_cnt<=iter_cnt+1 -> CHECK.
- CHECK: evaluates nonzero, which reflects the activations committed in UPDATE. First matching rule wins:
  - popcount(nonzero)==1 -> DONE; winner=index of the set bit.
  - popcount==0 -> DONE; no_winner=1, winner=0.
  - iter_cnt==MAX_ITER -> DONE; iter_limit=1, winner=lowest set index.
  - otherwise -> ISSUE.
- DONE: done=1; outputs are held. start=1 -> LOAD; done drops in that same cycle.
- start while busy is ignored; no queueing.
- Latency:
  - start to first dp_start is 2 cycles (IDLE->LOAD->ISSUE).
  - Each iteration is 3 cycles plus the datapath latency: ISSUE, WAIT (>=1), UPDATE, CHECK.
- Equal maxima (a tie) never converge. Such a search ends with iter_limit=1 and the lowest surviving index.
- iter_cnt saturates at MAX_ITER and never wraps.

Optional Feature:
- Macro: MAXNET_WDOG_EN.
- With the macro defined:
  - a counter runs while in WAIT and clears on entering ISSUE;
  - if it reaches WDOG_CYCLES without dp_valid, the FSM goes to DONE with output dp_timeout=1 (extra 1-bit port), winner=0, and without ld_act;
  - dp_timeout is cleared in LOAD and by rst.
- Without the macro: the dp_timeout port and the counter are absent, and WAIT waits indefinitely.

Test Plan:
- Nominal:
  - x=0x3e4ccccd, 0x3ecccccd, 0x3f19999a, 0x3f4ccccd (0.2/0.4/0.6/0.8).
  - Bench model returns nonzero=1111, 1110, 1100, 1000 (three iterations, dp latency 3).
  - Required: done=1, winner=3, iter_cnt=3, flags 0; ld_init once, dp_start and ld_act three times each.
- Tie: bench holds nonzero=0110 every iteration, MAX_ITER=32. Required: done after iteration 32, iter_limit=1, winner=1, iter_cnt=32.
- All zero: nonzero=0000 after the first UPDATE. Required: done, no_winner=1, winner=0, iter_cnt=1.
- Reset mid-WAIT: rst=1 during cycle 2 of WAIT. Required: next edge all outputs 0 and state IDLE; a later dp_valid pulse is ignored; a fresh start runs normally.
- Restart and ignore:
  - start pulsed during WAIT has no effect;
  - start in DONE gives ld_init on the next cycle, clears the flags and sets iter_cnt=0.
- MAXNET_WDOG_EN, WDOG_CYCLES=8: dp_valid never asserted. Required: exactly 8 cycles in WAIT, then DONE with dp_timeout=1 and no ld_act.
